pixel_fetch: RTL and testbench

Read-side counterpart to the Memory stage's pixel writes. Once the CPU has written a processed image quadrant into data memory, this block scans that quadrant back out. It reads row-major, one byte per address, through a dedicated synchronous read port. Pixels go out as a valid/ready stream toward the display/output logic. It sits beside the Memory stage on a second read port of data memory and never writes memory.

---
 rtl/pixel_pkg.sv | 24 ++
 rtl/pix_fifo2.sv | 53 +++++
 rtl/pixel_fetch.sv | 142 ++++++++++++++
 tb/tb_pixel_fetch.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel read-out path.
// Holds the scan FSM state encoding, the pixel byte type, the FIFO word
// layout and the default image geometry used by the Memory stage, this
// block and the display logic.
package pixel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef logic [7:0] pixel_t;

    typedef struct packed {
        logic   last;
        pixel_t data;
    } fifo_word_t;

    localparam int DEF_IMG_DIM  = 400;
    localparam int DEF_GRID     = 4;
    localparam int DEF_QUAD_DIM = DEF_IMG_DIM / DEF_GRID;

endpackage

// File: rtl/pix_fifo2.sv
// Two-entry synchronous FIFO carrying a pixel byte plus its last-pixel tag.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-low reset
//   push, wdata         write strobe and word
//   pop, rdata          read strobe and head word (head is valid when !empty)
//   count, empty, full  occupancy status
// Simultaneous push and pop are both honoured and leave count unchanged.
module pix_fifo2
    import pixel_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  fifo_word_t wdata,
    input  logic       pop,
    output fifo_word_t rdata,
    output logic [1:0] count,
    output logic       empty,
    output logic       full
);

    fifo_word_t mem [2];
    logic       wr_ptr;
    logic       rd_ptr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign empty = (count == 2'd0);
    assign full  = (count == 2'd2);

endmodule

// File: rtl/pixel_fetch.sv
// Scans one image quadrant out of data memory, row-major, one byte per
// address, and streams the bytes out over a valid/ready interface.
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-low reset
//   start, cuadrante            scan request and quadrant index {qrow, qcol}
//   mem_rd_en, mem_addr         read strobe and byte address to the read port
//   mem_rdata                   read data, valid one cycle after mem_rd_en
//   pixel, pixel_valid,
//   pixel_ready, pixel_last     output stream; last marks the final pixel
//   busy, done                  scan in progress / one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// RUN   | issuing reads, one per cycle while the credit allows
// DRAIN | all reads issued; waiting for the last pixel to handshake
module pixel_fetch
    import pixel_pkg::*;
#(
    parameter int ADDR_W    = 19,
    parameter int IMG_DIM   = DEF_IMG_DIM,
    parameter int GRID      = DEF_GRID,
    parameter int QUAD_DIM  = DEF_QUAD_DIM,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        cuadrante,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        pixel,
    output logic              pixel_valid,
    input  logic              pixel_ready,
    output logic              pixel_last,
    output logic              busy,
    output logic              done
);

    localparam int GW = $clog2(GRID);
    localparam int CW = ($clog2(QUAD_DIM) > 0) ? $clog2(QUAD_DIM) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(QUAD_DIM - 1);

    fetch_state_t      state, state_nx;
    logic [CW-1:0]     row, col;
    logic [ADDR_W-1:0] row_base, start_base;
    logic [GW-1:0]     qrow, qcol;
    logic              inflight, inflight_last, done_q;
    logic              issue, pop, at_last, credit_ok;
    logic [2:0]        occupancy;
    logic [1:0]        fifo_count;
    logic              fifo_empty, fifo_full;
    fifo_word_t        head, push_word;

    assign qrow = cuadrante[2*GW-1:GW];
    assign qcol = cuadrante[GW-1:0];

    // Multiplies only on the start path; per-pixel stepping is add-only.
    assign start_base = ADDR_W'(BASE_ADDR)
                      + ADDR_W'(qrow) * ADDR_W'(QUAD_DIM * IMG_DIM)
                      + ADDR_W'(qcol) * ADDR_W'(QUAD_DIM);

    assign at_last = (row == LAST_IDX) && (col == LAST_IDX);
    assign pop     = pixel_valid && pixel_ready;

    // Items already owed to the FIFO (stored + returning) minus the one
    // leaving this cycle must leave room for one more.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight};
    assign credit_ok = (occupancy < (3'd2 + {2'b00, pop})) && !(fifo_full && !pop);

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = RUN;
            end
            RUN: begin
                issue = credit_ok;
                if (issue && at_last) state_nx = DRAIN;
            end
            DRAIN: begin
                if (pop && head.last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            row           <= '0;
            col           <= '0;
            row_base      <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state         <= state_nx;
            inflight      <= issue;
            inflight_last <= issue && at_last;
            done_q        <= (state == DRAIN) && pop && head.last;
            if (state == IDLE && start) begin
                row_base <= start_base;
                row      <= '0;
                col      <= '0;
            end else if (issue) begin
                if (col == LAST_IDX) begin
                    col      <= '0;
                    row      <= row + CW'(1);
                    row_base <= row_base + ADDR_W'(IMG_DIM);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    assign push_word.last = inflight_last;
    assign push_word.data = mem_rdata;

    pix_fifo2 u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inflight),
        .wdata (push_word),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign mem_rd_en   = issue;
    assign mem_addr    = row_base + ADDR_W'(col);
    assign pixel_valid = !fifo_empty;
    assign pixel       = head.data;
    assign pixel_last  = head.last && pixel_valid;
    assign busy        = (state != IDLE);
    assign done        = done_q;

endmodule

// File: tb/tb_pixel_fetch.sv
module tb_pixel_fetch;

    localparam int ADDR_W    = 19;
    localparam int IMG_DIM   = 8;
    localparam int GRID      = 4;
    localparam int QUAD_DIM  = 2;
    localparam int BASE_ADDR = 0;
    localparam int NPIX      = QUAD_DIM * QUAD_DIM;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [3:0]        cuadrante = 4'h0;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata = 8'h00;
    logic [7:0]        pixel;
    logic              pixel_valid;
    logic              pixel_ready = 1'b0;
    logic              pixel_last;
    logic              busy;
    logic              done;

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    int outstanding = 0;
    int credit_viol = 0;
    int stable_viol = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int busy_cnt = 0;
    logic [ADDR_W-1:0] rd_q[$];
    int                rd_cyc[$];
    logic [7:0]        px_q[$];
    logic              lst_q[$];
    int                px_cyc[$];
    logic              prev_stall = 1'b0;
    logic [7:0]        prev_pixel = 8'h00;
    logic              prev_last = 1'b0;

    pixel_fetch #(
        .ADDR_W    (ADDR_W),
        .IMG_DIM   (IMG_DIM),
        .GRID      (GRID),
        .QUAD_DIM  (QUAD_DIM),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cuadrante   (cuadrante),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .pixel       (pixel),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .pixel_last  (pixel_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Memory holds mem[a] = a[7:0], one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem_addr[7:0];
    end

    // Stream observer: logs reads and handshakes, tracks owed items.
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            if (mem_rd_en) begin
                rd_q.push_back(mem_addr);
                rd_cyc.push_back(cyc);
                outstanding++;
            end
            if (pixel_valid && pixel_ready) begin
                px_q.push_back(pixel);
                lst_q.push_back(pixel_last);
                px_cyc.push_back(cyc);
                outstanding--;
            end
            if (outstanding > 2 || outstanding < 0) credit_viol++;
            if (prev_stall && (!pixel_valid || pixel !== prev_pixel || pixel_last !== prev_last))
                stable_viol++;
            prev_stall = pixel_valid && !pixel_ready;
            prev_pixel = pixel;
            prev_last  = pixel_last;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy) busy_cnt++;
        end
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] exp_addr(input logic [3:0] q, input int k);
        int qr = int'(q) / GRID;
        int qc = int'(q) % GRID;
        int r  = k / QUAD_DIM;
        int c  = k % QUAD_DIM;
        return ADDR_W'(BASE_ADDR + (qr * QUAD_DIM + r) * IMG_DIM + qc * QUAD_DIM + c);
    endfunction

    task automatic clear_log();
        rd_q.delete();
        rd_cyc.delete();
        px_q.delete();
        lst_q.delete();
        px_cyc.delete();
        done_cnt    = 0;
        busy_cnt    = 0;
        credit_viol = 0;
        stable_viol = 0;
    endtask

    task automatic do_start(input logic [3:0] q, output int acc);
        @(posedge clk); #1;
        start     = 1'b1;
        cuadrante = q;
        @(posedge clk); #1;
        acc       = cyc;
        start     = 1'b0;
        cuadrante = 4'($urandom);
    endtask

    task automatic wait_done(input int budget, input bit rnd, input string tag);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk); #1;
            if (rnd) pixel_ready = 1'($urandom_range(0, 1));
            n++;
        end
        pixel_ready = 1'b1;
        chk(32'(done_cnt != 0), 32'd1, {tag, " done_seen"});
        repeat (3) @(negedge clk);
    endtask

    task automatic check_scan(input logic [3:0] q, input int acc, input bit tight, input string tag);
        logic [ADDR_W-1:0] a;
        chk(32'(rd_q.size()), 32'(NPIX), {tag, " n_reads"});
        chk(32'(px_q.size()), 32'(NPIX), {tag, " n_handshakes"});
        for (int i = 0; i < rd_q.size() && i < NPIX; i++) begin
            a = exp_addr(q, i);
            chk(32'(rd_q[i]), 32'(a), $sformatf("%s addr[%0d]", tag, i));
        end
        for (int i = 0; i < px_q.size() && i < NPIX; i++) begin
            a = exp_addr(q, i);
            chk(32'(px_q[i]), 32'(a[7:0]), $sformatf("%s pixel[%0d]", tag, i));
            chk(32'(lst_q[i]), 32'(i == NPIX - 1), $sformatf("%s last[%0d]", tag, i));
        end
        chk(32'(done_cnt), 32'd1, {tag, " done_pulses"});
        chk(32'(credit_viol), 32'd0, {tag, " overflow"});
        chk(32'(stable_viol), 32'd0, {tag, " stall_stable"});
        if (rd_q.size() > 0) begin
            chk(32'(rd_cyc[0]), 32'(acc + 1), {tag, " first_read_cycle"});
            chk(32'(busy_cnt), 32'(done_cyc - rd_cyc[0]), {tag, " busy_span"});
        end
        if (tight) begin
            for (int i = 0; i < rd_cyc.size() && i < NPIX; i++)
                chk(32'(rd_cyc[i]), 32'(acc + 1 + i), $sformatf("%s read_cycle[%0d]", tag, i));
            for (int i = 0; i < px_cyc.size() && i < NPIX; i++)
                chk(32'(px_cyc[i]), 32'(acc + 3 + i), $sformatf("%s pixel_cycle[%0d]", tag, i));
        end
    endtask

    initial begin
        int acc;
        int n;
        logic [3:0] q;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({mem_rd_en, 12'(mem_addr), pixel, pixel_valid, pixel_last, busy, done, 7'd0},
            32'd0, "reset_outputs");
        chk(32'(mem_addr), 32'd0, "reset_addr");
        @(posedge clk); #1;
        reset = 1'b1;

        // Basic scan, quadrant 2
        pixel_ready = 1'b1;
        clear_log();
        do_start(4'h2, acc);
        wait_done(50, 1'b0, "basic");
        check_scan(4'h2, acc, 1'b1, "basic");

        // Corner quadrant
        clear_log();
        do_start(4'hF, acc);
        wait_done(50, 1'b0, "corner");
        check_scan(4'hF, acc, 1'b1, "corner");

        // Backpressure on quadrant 0
        pixel_ready = 1'b0;
        clear_log();
        do_start(4'h0, acc);
        n = 0;
        while (!pixel_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({31'd0, pixel_valid}, 32'd1, "bp first_valid");
        chk(32'(pixel), 32'h00, "bp head");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk({23'd0, pixel_valid, pixel}, {23'd0, 1'b1, 8'h00}, $sformatf("bp hold[%0d]", k));
        end
        chk(32'(rd_q.size() <= 2), 32'd1, "bp reads_before_release");
        @(posedge clk); #1;
        pixel_ready = 1'b1;
        wait_done(50, 1'b0, "bp");
        check_scan(4'h0, acc, 1'b0, "bp");

        // Random ready, quadrant 5 then random quadrants
        for (int t = 0; t < 5; t++) begin
            q = (t == 0) ? 4'h5 : 4'($urandom);
            pixel_ready = 1'($urandom_range(0, 1));
            clear_log();
            do_start(q, acc);
            wait_done(400, 1'b1, $sformatf("rand%0d", t));
            check_scan(q, acc, 1'b0, $sformatf("rand%0d q=%0h", t, q));
        end

        // Start while busy is ignored
        pixel_ready = 1'b1;
        clear_log();
        do_start(4'h0, acc);
        start     = 1'b1;
        cuadrante = 4'h3;
        @(posedge clk); #1;
        start     = 1'b0;
        wait_done(50, 1'b0, "busy_start");
        repeat (4) @(negedge clk);
        check_scan(4'h0, acc, 1'b1, "busy_start");

        // Reset mid-scan
        clear_log();
        do_start(4'h0, acc);
        n = 0;
        while (px_q.size() < 2 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk(32'(px_q.size()), 32'd2, "rst pixels_before");
        reset       = 1'b0;
        pixel_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk({mem_rd_en, 12'(mem_addr), pixel, pixel_valid, pixel_last, busy, done, 7'd0},
            32'd0, "rst outputs");
        chk(32'(mem_addr), 32'd0, "rst addr");
        repeat (3) @(negedge clk);
        chk({30'd0, busy, pixel_valid}, 32'd0, "rst stays_idle");
        chk(32'(px_q.size()), 32'd2, "rst no_extra_pixels");
        pixel_ready = 1'b1;
        clear_log();
        do_start(4'h1, acc);
        wait_done(50, 1'b0, "after_rst");
        check_scan(4'h1, acc, 1'b1, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
